audio_i2s_serializer: RTL and testbench

- Parametrised successor of the fixed 16-bit stereo DAC serializer: N stereo data lanes, configurable sample and slot widths, selectable I2S or left-justified framing, and a programmable bit-clock divider.
- Adds a one-frame input buffer with a ready/valid handshake, underrun reporting and a frame-aligned mute.
- Sits between the sound mixer output (SOUND_IF producer) and the board DAC pins, clocked from the DAC clock domain.

---
 rtl/audio_i2s_serializer.sv | 157 +++++++++++++++
 tb/tb_audio_i2s_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_serializer.sv
// audio_i2s_serializer: multi-lane stereo serializer for I2S or left-justified DACs.
// Holds one buffered frame behind a ready/valid handshake. Generates BCLK/LRCLK
// and shifts each lane's samples out MSB first. Zeros go out on underrun or mute.
module audio_i2s_serializer #(
  parameter int BIT_WIDTH  = 16,
  parameter int SLOT_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int MODE       = 0,
  parameter int BCLK_DIV   = 1
) (
  input  logic                         CLK,
  input  logic                         RESET_n,
  input  logic [LANES*BIT_WIDTH-1:0]   SAMPLE_L,
  input  logic [LANES*BIT_WIDTH-1:0]   SAMPLE_R,
  input  logic                         SAMPLE_VALID,
  output logic                         SAMPLE_READY,
  input  logic                         MUTE,
  output logic                         UNDERRUN,
  output logic                         DAC_BCLK,
  output logic                         DAC_LRCLK,
  output logic [LANES-1:0]             DAC_DIN
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CW = $clog2(FRAME_BITS);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] SLOT_BITS = CW'(SLOT_WIDTH);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);

  // Reject unsupported configurations at elaboration time
  if (BIT_WIDTH > SLOT_WIDTH) begin : g_err_bit_width
    $error("BIT_WIDTH (%0d) must not exceed SLOT_WIDTH (%0d)", BIT_WIDTH, SLOT_WIDTH);
  end
  if (SLOT_WIDTH != 16 && SLOT_WIDTH != 24 && SLOT_WIDTH != 32) begin : g_err_slot_width
    $error("SLOT_WIDTH must be 16, 24 or 32");
  end
  if (LANES < 1 || LANES > 4) begin : g_err_lanes
    $error("LANES must be in 1..4");
  end
  if (MODE != 0 && MODE != 1) begin : g_err_mode
    $error("MODE must be 0 (I2S) or 1 (left-justified)");
  end
  if (BCLK_DIV < 1) begin : g_err_div
    $error("BCLK_DIV must be >= 1");
  end

  logic [DW-1:0]              div_reg;
  logic                       bclk_reg;
  logic [CW-1:0]              count_reg;
  logic                       full_reg;
  logic                       underrun_reg;
  logic [LANES*BIT_WIDTH-1:0] buf_l_reg;
  logic [LANES*BIT_WIDTH-1:0] buf_r_reg;

  logic div_wrap;
  logic bclk_fall;
  logic frame_start;
  logic accept;
  logic load_data;

  assign div_wrap    = (div_reg == DIV_LAST);
  assign bclk_fall   = div_wrap && bclk_reg;
  assign frame_start = bclk_fall && (count_reg == LAST_BIT);
  assign accept      = SAMPLE_VALID && !full_reg;
  // Real samples go out only when a frame was buffered and mute is off
  assign load_data   = full_reg && !MUTE;

  assign DAC_BCLK     = bclk_reg;
  assign DAC_LRCLK    = (count_reg >= SLOT_BITS);
  assign SAMPLE_READY = !full_reg;
  assign UNDERRUN     = underrun_reg;

  // Bit-clock divider: toggle BCLK each time the half-period counter wraps
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      div_reg  <= '0;
      bclk_reg <= 1'b0;
    end else if (div_wrap) begin
      div_reg  <= '0;
      bclk_reg <= !bclk_reg;
    end else begin
      div_reg  <= div_reg + DW'(1);
    end
  end

  // Bit position within the frame; reset value makes the first falling edge a frame start
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      count_reg <= LAST_BIT;
    end else if (bclk_fall) begin
      count_reg <= (count_reg == LAST_BIT) ? '0 : count_reg + CW'(1);
    end
  end

  // One-frame buffer: fill on accept, drain at frame start, flag empty frame starts
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      full_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      buf_l_reg    <= '0;
      buf_r_reg    <= '0;
    end else begin
      underrun_reg <= frame_start && !full_reg;
      if (frame_start && full_reg) begin
        full_reg <= 1'b0;
      end else if (accept) begin
        full_reg  <= 1'b1;
        buf_l_reg <= SAMPLE_L;
        buf_r_reg <= SAMPLE_R;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [BIT_WIDTH-1:0]  lane_l;
    logic [BIT_WIDTH-1:0]  lane_r;
    logic [SLOT_WIDTH-1:0] slot_l;
    logic [SLOT_WIDTH-1:0] slot_r;
    logic [FRAME_BITS-1:0] shift_reg;

    assign lane_l = buf_l_reg[gi*BIT_WIDTH +: BIT_WIDTH];
    assign lane_r = buf_r_reg[gi*BIT_WIDTH +: BIT_WIDTH];
    // Sample sits MSB-aligned in its slot, padded with trailing zeros
    assign slot_l = SLOT_WIDTH'(lane_l) << (SLOT_WIDTH - BIT_WIDTH);
    assign slot_r = SLOT_WIDTH'(lane_r) << (SLOT_WIDTH - BIT_WIDTH);

    // Frame shifter: load at frame start, otherwise shift one bit per BCLK falling edge
    always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
        shift_reg <= '0;
      end else if (frame_start) begin
        shift_reg <= load_data ? {slot_l, slot_r} : '0;
      end else if (bclk_fall) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
      end
    end

    if (MODE == 1) begin : g_lj
      assign DAC_DIN[gi] = shift_reg[FRAME_BITS-1];
    end else begin : g_i2s
      logic dly_reg;

      // I2S delay: emit each bit one BCLK after it reaches the shifter MSB
      always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
          dly_reg <= 1'b0;
        end else if (bclk_fall) begin
          dly_reg <= shift_reg[FRAME_BITS-1];
        end
      end

      assign DAC_DIN[gi] = dly_reg;
    end
  end

endmodule

// File: tb/tb_audio_i2s_serializer.sv
// Directed bench for audio_i2s_serializer: an I2S 16/16 single-lane instance and a
// left-justified 16/32 two-lane instance with BCLK_DIV=4, checked against hand-derived streams.
module tb_audio_i2s_serializer;

  logic        clk;
  logic        rst0_n, rst1_n;
  logic [15:0] l0, r0;
  logic        valid0, ready0, mute0, urun0, bclk0, lrclk0;
  logic [0:0]  din0;
  logic [31:0] l1, r1;
  logic        valid1, ready1, mute1, urun1, bclk1, lrclk1;
  logic [1:0]  din1;

  int checks = 0;
  int errors = 0;

  logic [63:0] va, vb;
  int rl, ur, lh;

  audio_i2s_serializer #(
    .BIT_WIDTH(16), .SLOT_WIDTH(16), .LANES(1), .MODE(0), .BCLK_DIV(1)
  ) dut0 (
    .CLK(clk), .RESET_n(rst0_n),
    .SAMPLE_L(l0), .SAMPLE_R(r0),
    .SAMPLE_VALID(valid0), .SAMPLE_READY(ready0),
    .MUTE(mute0), .UNDERRUN(urun0),
    .DAC_BCLK(bclk0), .DAC_LRCLK(lrclk0), .DAC_DIN(din0)
  );

  audio_i2s_serializer #(
    .BIT_WIDTH(16), .SLOT_WIDTH(32), .LANES(2), .MODE(1), .BCLK_DIV(4)
  ) dut1 (
    .CLK(clk), .RESET_n(rst1_n),
    .SAMPLE_L(l1), .SAMPLE_R(r1),
    .SAMPLE_VALID(valid1), .SAMPLE_READY(ready1),
    .MUTE(mute1), .UNDERRUN(urun1),
    .DAC_BCLK(bclk1), .DAC_LRCLK(lrclk1), .DAC_DIN(din1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Record DIN once per bit (starting at a frame-start edge), counting READY-low,
  // UNDERRUN-high and LRCLK-high samples over every CLK of the window.
  task automatic capture(input int sel, input int nbits, input int spb,
                         output logic [63:0] a, output logic [63:0] b,
                         output int rdy_low, output int urun, output int lr_hi);
    a = '0; b = '0; rdy_low = 0; urun = 0; lr_hi = 0;
    for (int k = 0; k < nbits; k++) begin
      if (sel == 0) begin
        a = {a[62:0], din0[0]};
      end else begin
        a = {a[62:0], din1[0]};
        b = {b[62:0], din1[1]};
      end
      for (int s = 0; s < spb; s++) begin
        step();
        if (sel == 0) begin
          if (!ready0) rdy_low++;
          if (urun0) urun++;
          if (lrclk0) lr_hi++;
        end else begin
          if (!ready1) rdy_low++;
          if (urun1) urun++;
          if (lrclk1) lr_hi++;
        end
      end
    end
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0; mute0 = 1'b0; mute1 = 1'b0;
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    repeat (3) step();

    // ---------------- I2S instance ----------------
    check("d0_reset_outs", 64'({bclk0, lrclk0, din0, ready0, urun0}), 64'(5'b01010));
    rst0_n = 1'b1;
    step();
    check("d0_first_rise", 64'({bclk0, lrclk0, urun0}), 64'(3'b110));
    valid0 = 1'b1; l0 = 16'h8001; r0 = 16'h7FFE;
    step();
    valid0 = 1'b0;
    // accept coincides with the first frame start: that frame underruns
    check("d0_fs1", 64'({bclk0, lrclk0, urun0, ready0}), 64'(4'b0010));
    capture(0, 32, 2, va, vb, rl, ur, lh);
    check("d0_f1_din", 64'(va[31:0]), 64'h0);
    check("d0_f1_ready_low", 64'(rl), 64'd63);
    check("d0_f1_urun", 64'(ur), 64'd0);
    check("d0_f1_lrclk_hi", 64'(lh), 64'd32);
    check("d0_fs2", 64'({lrclk0, urun0, ready0}), 64'(3'b001));
    capture(0, 32, 2, va, vb, rl, ur, lh);
    check("d0_f2_din", 64'(va[31:0]), 64'h4000BFFF);
    check("d0_f2_ready_low", 64'(rl), 64'd0);
    check("d0_f2_urun", 64'(ur), 64'd1);
    capture(0, 64, 2, va, vb, rl, ur, lh);
    check("d0_f34_din", va, 64'h0);
    check("d0_f34_urun", 64'(ur), 64'd2);
    check("d0_f34_lrclk_hi", 64'(lh), 64'd64);

    // reset mid-left-slot with a frame in flight and another buffered
    valid0 = 1'b1; l0 = 16'hFFFF; r0 = 16'hFFFF;
    step();
    valid0 = 1'b0;
    check("d0_acc_d", 64'(ready0), 64'd0);
    repeat (63) step();
    check("d0_fs_load_d", 64'({lrclk0, urun0, ready0}), 64'(3'b001));
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    repeat (7) step();
    check("d0_pre_reset", 64'({bclk0, lrclk0, din0, ready0}), 64'(4'b0010));
    #2 rst0_n = 1'b0;
    #1;
    check("d0_async_reset", 64'({bclk0, lrclk0, din0, ready0, urun0}), 64'(5'b01010));
    step();
    rst0_n = 1'b1;
    step();
    check("d0_rel_rise", 64'({bclk0, lrclk0, urun0}), 64'(3'b110));
    step();
    check("d0_rel_fs", 64'({bclk0, lrclk0, urun0, ready0, din0}), 64'(5'b00110));
    capture(0, 32, 2, va, vb, rl, ur, lh);
    check("d0_rel_f_din", 64'(va[31:0]), 64'h0);
    check("d0_rel_f_urun", 64'(ur), 64'd1);

    // ---------------- left-justified two-lane instance ----------------
    check("d1_reset_outs", 64'({bclk1, lrclk1, din1, ready1, urun1}), 64'(6'b010010));
    rst1_n = 1'b1; valid1 = 1'b1;
    l1 = {16'h0001, 16'hFFFF}; r1 = {16'h8000, 16'h1234};
    step();
    valid1 = 1'b0;
    check("d1_acc_a", 64'(ready1), 64'd0);
    repeat (3) step();
    check("d1_first_rise", 64'({bclk1, lrclk1}), 64'(2'b11));
    repeat (3) step();
    check("d1_hold_high", 64'({bclk1, lrclk1}), 64'(2'b11));
    step();
    // MSB is already on DIN at the edge where LRCLK falls
    check("d1_fs1", 64'({bclk1, lrclk1, urun1, ready1, din1}), 64'(6'b000101));
    valid1 = 1'b1; l1 = {16'h5555, 16'hAAAA}; r1 = {16'hF00F, 16'h00FF};
    capture(1, 64, 8, va, vb, rl, ur, lh);
    check("d1_f1_lane0", va, 64'hFFFF0000_12340000);
    check("d1_f1_lane1", vb, 64'h00010000_80000000);
    check("d1_f1_ready_low", 64'(rl), 64'd511);
    check("d1_f1_urun", 64'(ur), 64'd0);
    check("d1_f1_lrclk_hi", 64'(lh), 64'd256);
    capture(1, 32, 8, va, vb, rl, ur, lh);
    check("d1_f2a_lane0", 64'(va[31:0]), 64'hAAAA0000);
    check("d1_f2a_lane1", 64'(vb[31:0]), 64'h55550000);
    check("d1_f2a_ready_low", 64'(rl), 64'd256);
    check("d1_f2a_lrclk_hi", 64'(lh), 64'd1);
    mute1 = 1'b1; valid1 = 1'b0;
    capture(1, 32, 8, va, vb, rl, ur, lh);
    check("d1_f2b_lane0", 64'(va[31:0]), 64'h00FF0000);
    check("d1_f2b_lane1", 64'(vb[31:0]), 64'hF00F0000);
    check("d1_f2b_ready_low", 64'(rl), 64'd255);
    check("d1_f2b_urun", 64'(ur), 64'd0);
    capture(1, 64, 8, va, vb, rl, ur, lh);
    check("d1_f3_lane0_muted", va, 64'h0);
    check("d1_f3_lane1_muted", vb, 64'h0);
    check("d1_f3_ready_low", 64'(rl), 64'd0);
    check("d1_f3_urun", 64'(ur), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
